mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 61 ++++++
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - handshake and shared-memory bundle for mem_port_arbiter
//
// Groups the fetch requester, the data requester and the single shared
// memory port into one bundle.
//   slave  : arbiter view. It takes the requests and mem_read_data, and it
//            drives the grants, completions, response data, memory command
//            and busy.
//   master : environment view. It holds the requesters and the memory model.
//
// Fetch side : if_req, if_addr -> if_gnt, if_done, if_rdata
// Data side  : dm_req, dm_we, dm_addr, dm_wdata, dm_funct3
//              -> dm_gnt, dm_done, dm_rdata
// Memory     : mem_read_address, mem_write_address, mem_write_data,
//              mem_write_en, mem_funct3 -> mem_read_data
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_done;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_funct3;
  logic        dm_gnt;
  logic        dm_done;
  logic [31:0] dm_rdata;

  logic [31:0] mem_read_address;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_read_data;

  logic        busy;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_funct3,
    input  mem_read_data,
    output if_gnt, if_done, if_rdata,
    output dm_gnt, dm_done, dm_rdata,
    output mem_read_address, mem_write_address, mem_write_data,
    output mem_write_en, mem_funct3,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_funct3,
    output mem_read_data,
    input  if_gnt, if_done, if_rdata,
    input  dm_gnt, dm_done, dm_rdata,
    input  mem_read_address, mem_write_address, mem_write_data,
    input  mem_write_en, mem_funct3,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter onto one shared memory port
//
// Shares one memory port between an instruction-fetch requester and a data
// requester. Only one transaction is in flight at a time:
//   IDLE -> ISSUE -> (WAIT)* -> RESP -> IDLE
//
// A grant is given only in IDLE. It is combinational and lasts one cycle.
// The winner's fields are captured at that clock edge, so later changes on
// the requester side do not disturb the transaction in flight.
//
// Parameters
//   RD_LAT : memory read latency in cycles (legal range 1..4)
//
// Ports
//   clk    : clock; all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave, which carries the fetch and data
//            handshakes, the shared memory port and busy
//
// Build option
//   MEM_ARB_RR_EN : when defined, conflicts alternate through a 1-bit
//                   round-robin pointer, starting with the data port after
//                   reset. When undefined, the data port always wins.
module mem_port_arbiter #(
  parameter int RD_LAT = 1
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // WAIT covers latency beyond the ISSUE cycle. The counter runs down to 0
  // inclusive, so it is loaded with RD_LAT-2. When RD_LAT is 1, WAIT is
  // never entered.
  localparam int         CNT_INIT     = (RD_LAT > 1) ? RD_LAT - 2 : 0;
  localparam logic [1:0] CNT_LOAD     = 2'(CNT_INIT);
  localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic        own_dm_q, own_dm_d;

  logic        pick_dm;
  logic        pick_if;
  logic        grant_dm;
  logic        grant_if;
  logic        in_resp;

`ifdef MEM_ARB_RR_EN
  // rr_q == 0 favours the data port and rr_q == 1 favours the fetch port.
  logic        rr_q, rr_d;

  assign pick_dm = bus.dm_req & (~bus.if_req | ~rr_q);
`else
  assign pick_dm = bus.dm_req;
`endif
  assign pick_if = bus.if_req & ~pick_dm;

  // Next state, grant and capture of the winner's fields
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    own_dm_d = own_dm_q;
    grant_dm = 1'b0;
    grant_if = 1'b0;
`ifdef MEM_ARB_RR_EN
    rr_d     = rr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pick_dm) begin
          grant_dm = 1'b1;
          own_dm_d = 1'b1;
          addr_d   = bus.dm_addr;
          wdata_d  = bus.dm_wdata;
          funct3_d = bus.dm_funct3;
          we_d     = bus.dm_we;
          state_d  = S_ISSUE;
`ifdef MEM_ARB_RR_EN
          rr_d     = 1'b1;
`endif
        end else if (pick_if) begin
          // Fetches are always word reads.
          grant_if = 1'b1;
          own_dm_d = 1'b0;
          addr_d   = bus.if_addr;
          wdata_d  = '0;
          funct3_d = FETCH_FUNCT3;
          we_d     = 1'b0;
          state_d  = S_ISSUE;
`ifdef MEM_ARB_RR_EN
          rr_d     = 1'b0;
`endif
        end
      end

      S_ISSUE: begin
        if (we_q || (RD_LAT == 1)) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end

      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      own_dm_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      own_dm_q <= own_dm_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign in_resp = (state_q == S_RESP);

  // The grant is combinational from req. It is masked by rst_n so that no
  // grant shows while reset is asserted.
  assign bus.if_gnt = grant_if & rst_n;
  assign bus.dm_gnt = grant_dm & rst_n;

  assign bus.if_done  = in_resp & ~own_dm_q;
  assign bus.dm_done  = in_resp &  own_dm_q;
  assign bus.if_rdata = (in_resp & ~own_dm_q & ~we_q) ? bus.mem_read_data : '0;
  assign bus.dm_rdata = (in_resp &  own_dm_q & ~we_q) ? bus.mem_read_data : '0;

  // The memory command comes straight from the capture registers. It holds
  // steady from ISSUE through RESP, and the asynchronous reset clears it.
  assign bus.mem_read_address  = addr_q;
  assign bus.mem_write_address = addr_q;
  assign bus.mem_write_data    = wdata_q;
  assign bus.mem_funct3        = funct3_q;
  assign bus.mem_write_en      = (state_q == S_ISSUE) & we_q;

  assign bus.busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (RD_LAT 1 and 3)
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;

  always #5 clk = ~clk;

  // Requester stimulus. Requests go only to the DUT that sel picks.
  logic        d_if_req, d_dm_req, d_dm_we;
  logic [31:0] d_if_addr, d_dm_addr, d_dm_wdata;
  logic [2:0]  d_dm_funct3;

  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter_if u_if1();
  mem_port_arbiter_if u_if3();

  mem_port_arbiter #(.RD_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1));
  mem_port_arbiter #(.RD_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(u_if3));

  assign u_if1.if_req    = ~sel & d_if_req;
  assign u_if1.dm_req    = ~sel & d_dm_req;
  assign u_if3.if_req    =  sel & d_if_req;
  assign u_if3.dm_req    =  sel & d_dm_req;
  assign u_if1.if_addr   = d_if_addr;
  assign u_if3.if_addr   = d_if_addr;
  assign u_if1.dm_we     = d_dm_we;
  assign u_if3.dm_we     = d_dm_we;
  assign u_if1.dm_addr   = d_dm_addr;
  assign u_if3.dm_addr   = d_dm_addr;
  assign u_if1.dm_wdata  = d_dm_wdata;
  assign u_if3.dm_wdata  = d_dm_wdata;
  assign u_if1.dm_funct3 = d_dm_funct3;
  assign u_if3.dm_funct3 = d_dm_funct3;

  // Physical memory seen by both DUTs: 256 words, indexed by address bits [9:2]
  logic [31:0] phys_mem [0:255];
  logic        seeded = 1'b0;

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 256; i++) phys_mem[i] <= seed_word(i);
      seeded <= 1'b1;
    end else begin
      if (u_if1.mem_write_en) phys_mem[u_if1.mem_write_address[9:2]] <= u_if1.mem_write_data;
      if (u_if3.mem_write_en) phys_mem[u_if3.mem_write_address[9:2]] <= u_if3.mem_write_data;
    end
  end

  assign u_if1.mem_read_data = phys_mem[u_if1.mem_read_address[9:2]];
  assign u_if3.mem_read_data = phys_mem[u_if3.mem_read_address[9:2]];

  // Reference memory, updated by the bench's own view of completed writes
  logic [31:0] ref_mem [0:255];

  // Outputs of the selected DUT
  logic        o_if_gnt, o_if_done, o_dm_gnt, o_dm_done, o_mem_write_en, o_busy;
  logic [31:0] o_if_rdata, o_dm_rdata, o_mem_read_address, o_mem_write_address, o_mem_write_data;
  logic [2:0]  o_mem_funct3;
  logic [168:0] snap;

  assign o_if_gnt            = sel ? u_if3.if_gnt            : u_if1.if_gnt;
  assign o_if_done           = sel ? u_if3.if_done           : u_if1.if_done;
  assign o_if_rdata          = sel ? u_if3.if_rdata          : u_if1.if_rdata;
  assign o_dm_gnt            = sel ? u_if3.dm_gnt            : u_if1.dm_gnt;
  assign o_dm_done           = sel ? u_if3.dm_done           : u_if1.dm_done;
  assign o_dm_rdata          = sel ? u_if3.dm_rdata          : u_if1.dm_rdata;
  assign o_mem_read_address  = sel ? u_if3.mem_read_address  : u_if1.mem_read_address;
  assign o_mem_write_address = sel ? u_if3.mem_write_address : u_if1.mem_write_address;
  assign o_mem_write_data    = sel ? u_if3.mem_write_data    : u_if1.mem_write_data;
  assign o_mem_write_en      = sel ? u_if3.mem_write_en      : u_if1.mem_write_en;
  assign o_mem_funct3        = sel ? u_if3.mem_funct3        : u_if1.mem_funct3;
  assign o_busy              = sel ? u_if3.busy              : u_if1.busy;
  assign snap = {o_if_gnt, o_if_done, o_if_rdata, o_dm_gnt, o_dm_done, o_dm_rdata,
                 o_mem_read_address, o_mem_write_address, o_mem_write_data,
                 o_mem_write_en, o_mem_funct3, o_busy};

  task automatic clear_req();
    d_if_req = 0; d_dm_req = 0; d_dm_we = 0;
    d_if_addr = 0; d_dm_addr = 0; d_dm_wdata = 0; d_dm_funct3 = 0;
  endtask

  // One isolated transaction on the selected DUT, checked cycle by cycle
  task automatic run_txn(input bit is_dm, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] f3);
    int          lat, exp_done;
    logic [31:0] exp_rd, own_rd, oth_rd;
    logic [2:0]  exp_f3;
    lat      = sel ? 3 : 1;
    exp_done = we ? 2 : 1 + lat;
    exp_rd   = we ? 32'd0 : ref_mem[addr[9:2]];
    exp_f3   = is_dm ? f3 : 3'b010;

    @(posedge clk); #1;
    if (is_dm) begin
      d_dm_req = 1; d_dm_we = we; d_dm_addr = addr; d_dm_wdata = wd; d_dm_funct3 = f3;
    end else begin
      d_if_req = 1; d_if_addr = addr;
    end
    #1;
    n_chk++;
    if ({o_dm_gnt, o_if_gnt} !== {is_dm, !is_dm}) begin
      n_fail++; $display("FAIL gnt_c0 got dm/if=%b%b exp %b%b", o_dm_gnt, o_if_gnt, is_dm, !is_dm);
    end

    // Cycle 1 (ISSUE). Scramble the requester fields to show they were latched.
    @(posedge clk); #1;
    d_if_req = 0; d_dm_req = 0;
    d_dm_addr = ~addr; d_if_addr = ~addr; d_dm_wdata = ~wd; d_dm_we = !we; d_dm_funct3 = ~f3;
    #1;
    n_chk++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL busy_c1 got %b exp 1", o_busy); end
    n_chk++;
    if (o_mem_write_en !== we) begin n_fail++; $display("FAIL wen_c1 got %b exp %b", o_mem_write_en, we); end
    n_chk++;
    if (o_mem_read_address !== addr || o_mem_write_address !== addr) begin
      n_fail++; $display("FAIL addr_c1 got rd=%h wr=%h exp %h", o_mem_read_address, o_mem_write_address, addr);
    end
    n_chk++;
    if (o_mem_funct3 !== exp_f3) begin n_fail++; $display("FAIL funct3_c1 got %b exp %b", o_mem_funct3, exp_f3); end
    if (we) begin
      n_chk++;
      if (o_mem_write_data !== wd) begin n_fail++; $display("FAIL wdata_c1 got %h exp %h", o_mem_write_data, wd); end
    end

    for (int c = 2; c <= exp_done + 1; c++) begin
      @(posedge clk); #2;
      own_rd = is_dm ? o_dm_rdata : o_if_rdata;
      oth_rd = is_dm ? o_if_rdata : o_dm_rdata;
      n_chk++;
      if (o_mem_write_en !== 1'b0) begin n_fail++; $display("FAIL wen_c%0d got %b exp 0", c, o_mem_write_en); end
      n_chk++;
      if (o_mem_read_address !== addr) begin
        n_fail++; $display("FAIL addr_hold_c%0d got %h exp %h", c, o_mem_read_address, addr);
      end
      if (c < exp_done) begin
        n_chk++;
        if ({o_busy, o_dm_done, o_if_done} !== 3'b100) begin
          n_fail++; $display("FAIL wait_c%0d got busy/dd/id=%b%b%b exp 100", c, o_busy, o_dm_done, o_if_done);
        end
      end else if (c == exp_done) begin
        n_chk++;
        if ({o_busy, o_dm_done, o_if_done} !== {1'b1, is_dm, !is_dm}) begin
          n_fail++; $display("FAIL done_c%0d got busy/dd/id=%b%b%b exp 1%b%b", c, o_busy, o_dm_done, o_if_done, is_dm, !is_dm);
        end
        n_chk++;
        if (own_rd !== exp_rd) begin n_fail++; $display("FAIL rdata_own got %h exp %h", own_rd, exp_rd); end
        n_chk++;
        if (oth_rd !== 32'd0) begin n_fail++; $display("FAIL rdata_other got %h exp 0", oth_rd); end
      end else begin
        n_chk++;
        if ({o_busy, o_dm_done, o_if_done} !== 3'b000) begin
          n_fail++; $display("FAIL idle_after got busy/dd/id=%b%b%b exp 000", o_busy, o_dm_done, o_if_done);
        end
      end
    end
    if (we) ref_mem[addr[9:2]] = wd;
    clear_req();
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; sel = 0;
    d_if_req = 1; d_dm_req = 1; d_dm_we = 1;
    d_if_addr = $urandom; d_dm_addr = $urandom; d_dm_wdata = $urandom; d_dm_funct3 = 3'b111;
    repeat (3) @(posedge clk);
    #2;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      n_chk++;
      if (snap !== '0) begin n_fail++; $display("FAIL reset_outputs sel=%0d got %h exp 0", s, snap); end
    end
    sel = 0;
    clear_req();
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_fetch_basic();
    sel = 0;
    run_txn(1'b0, 1'b0, 32'h0000_0010, 32'd0, 3'b000);
  endtask

  task automatic test_store_load();
    sel = 0;
    run_txn(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 3'b010);
    run_txn(1'b1, 1'b0, 32'h0000_0100, 32'd0, 3'b010);
    run_txn(1'b0, 1'b0, 32'h0000_0100, 32'd0, 3'b000);
  endtask

  task automatic test_rd_lat3();
    sel = 1;
    run_txn(1'b1, 1'b0, 32'h0000_0040, 32'd0, 3'b010);
    run_txn(1'b1, 1'b1, 32'h0000_0044, 32'h0BAD_F00D, 3'b001);
    run_txn(1'b0, 1'b0, 32'h0000_0044, 32'd0, 3'b000);
    sel = 0;
  endtask

  task automatic test_random();
    bit          is_dm, we;
    logic [31:0] a, wd, r;
    logic [2:0]  f3;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int k = 0; k < 25; k++) begin
        is_dm = 1'($urandom_range(0, 1));
        we    = is_dm ? 1'($urandom_range(0, 1)) : 1'b0;
        r     = $urandom_range(0, 255);
        a     = {22'd0, r[7:0], 2'b00};
        wd    = $urandom;
        f3    = 3'($urandom_range(0, 7));
        run_txn(is_dm, we, a, wd, f3);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end
    sel = 0;
  endtask

  // Both requesters held high. Expect four grants in the policy order, three
  // cycles apart, then the fetch grant once data drops out.
  task automatic test_arbitration();
    int ngr, last;
    bit exp_dm, got_dm;
    sel = 0;
    pulse_reset();
    @(posedge clk); #1;
    d_dm_req = 1; d_dm_we = 0; d_dm_addr = 32'h80; d_dm_funct3 = 3'b010;
    d_if_req = 1; d_if_addr = 32'h84;
    ngr = 0; last = -1;
    for (int c = 0; c < 60 && ngr < 5; c++) begin
      #1;
      if (o_if_gnt || o_dm_gnt) begin
        n_chk++;
        if (o_if_gnt && o_dm_gnt) begin n_fail++; $display("FAIL arb_both_gnt at grant %0d", ngr); end
        got_dm = o_dm_gnt;
`ifdef MEM_ARB_RR_EN
        exp_dm = (ngr < 4) ? (ngr % 2 == 0) : 1'b0;
`else
        exp_dm = (ngr < 4);
`endif
        n_chk++;
        if (got_dm !== exp_dm) begin n_fail++; $display("FAIL arb_order grant %0d got dm=%b exp dm=%b", ngr, got_dm, exp_dm); end
        if (last >= 0) begin
          n_chk++;
          if (c - last != 3) begin n_fail++; $display("FAIL arb_spacing got %0d exp 3", c - last); end
        end
        last = c;
        ngr++;
      end
      @(posedge clk); #1;
      if (ngr == 4) d_dm_req = 0;
    end
    n_chk++;
    if (ngr != 5) begin n_fail++; $display("FAIL arb_grant_count got %0d exp 5", ngr); end
    clear_req();
    repeat (4) @(posedge clk);
  endtask

  // A request that arrives while busy must wait for the next IDLE
  task automatic test_hold_off();
    sel = 0;
    @(posedge clk); #1;
    d_dm_req = 1; d_dm_we = 0; d_dm_addr = 32'h20; d_dm_funct3 = 3'b010;
    #1;
    n_chk++;
    if (o_dm_gnt !== 1'b1) begin n_fail++; $display("FAIL hold_dm_gnt got %b exp 1", o_dm_gnt); end
    @(posedge clk); #1;
    d_dm_req = 0; d_if_req = 1; d_if_addr = 32'h24;
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_chk++;
      if (o_if_gnt !== (c == 3)) begin n_fail++; $display("FAIL hold_if_gnt_c%0d got %b exp %b", c, o_if_gnt, (c == 3)); end
      @(posedge clk); #1;
    end
    d_if_req = 0;
    repeat (3) @(posedge clk);
    clear_req();
  endtask

  task automatic test_reset_mid_issue();
    sel = 0;
    @(posedge clk); #1;
    d_dm_req = 1; d_dm_we = 1; d_dm_addr = 32'h200; d_dm_wdata = 32'h1234_5678; d_dm_funct3 = 3'b010;
    #1;
    n_chk++;
    if (o_dm_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt got %b exp 1", o_dm_gnt); end
    @(posedge clk); #1;
    d_dm_req = 0;
    #1;
    n_chk++;
    if (o_mem_write_en !== 1'b1) begin n_fail++; $display("FAIL rmid_wen_before got %b exp 1", o_mem_write_en); end
    #1; rst_n = 0;
    #1;
    n_chk++;
    if (snap !== '0) begin n_fail++; $display("FAIL rmid_async_clear got %h exp 0", snap); end
    d_dm_req = 1;
    #1;
    n_chk++;
    if (o_dm_gnt !== 1'b0) begin n_fail++; $display("FAIL rmid_gnt_in_reset got %b exp 0", o_dm_gnt); end
    clear_req();
    @(negedge clk); rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      n_chk++;
      if ({o_busy, o_dm_done, o_if_done} !== 3'b000) begin
        n_fail++; $display("FAIL rmid_no_done got busy/dd/id=%b%b%b exp 000", o_busy, o_dm_done, o_if_done);
      end
    end
    run_txn(1'b1, 1'b0, 32'h200, 32'd0, 3'b010);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
    clear_req();
    test_reset();
    test_fetch_basic();
    test_store_load();
    test_rd_lat3();
    test_hold_off();
    test_random();
    test_reset_mid_issue();
    test_arbitration();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
